// File: rtl/conway_board.sv
// Game of Life board: row-serial loading, single-step or free-running evolution,
// generation counter and still-life flag. One conway_logic instance per cell.

module conway_logic (
  input  logic [7:0] nbr_i,
  input  logic       prev_state_i,
  output logic       next_state_o
);

  logic [3:0] count_s;

  // Live-neighbour count and the birth/survival rule
  always_comb begin
    count_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_s = count_s + {3'd0, nbr_i[i]};
    end
    next_state_o = (count_s == 4'd3) || (prev_state_i && (count_s == 4'd2));
  end

endmodule

module conway_board #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int WRAP   = 1,
  parameter int PERIOD = 1,
  parameter int GEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [COLS-1:0]      load_row,
  output logic                 load_ready,
  output logic                 load_done,
  input  logic                 run_en,
  input  logic                 single_step,
  output logic [ROWS*COLS-1:0] cells,
  output logic [GEN_W-1:0]     generation,
  output logic                 stable,
  output logic                 busy
);

  localparam int PTR_W = $clog2(ROWS);
  localparam int PRE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STEP} state_e;

  state_e               state_q, state_d;
  logic [ROWS*COLS-1:0] board_q, board_d, next_board_s;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [GEN_W-1:0]     gen_q, gen_d;
  logic                 stable_q, stable_d;
  logic                 done_q, busy_q, ready_q;
  logic                 update_s, load_wr_s, load_last_s;

  // Index is always folded into range; off-board cells are masked when not wrapping
  function automatic logic cell_at(input logic [ROWS*COLS-1:0] b, input int r, input int c);
    int rr;
    int cc;
    bit in_range;
    rr       = (r + ROWS) % ROWS;
    cc       = (c + COLS) % COLS;
    in_range = (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    return ((WRAP != 0) || in_range) ? b[rr * COLS + cc] : 1'b0;
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr_s;
      // {SE, S, SW, E, W, NE, N, NW}
      assign nbr_s = {cell_at(board_q, r + 1, c + 1), cell_at(board_q, r + 1, c),
                      cell_at(board_q, r + 1, c - 1), cell_at(board_q, r, c + 1),
                      cell_at(board_q, r, c - 1),     cell_at(board_q, r - 1, c + 1),
                      cell_at(board_q, r - 1, c),     cell_at(board_q, r - 1, c - 1)};
      conway_logic u_cell (
        .nbr_i        (nbr_s),
        .prev_state_i (board_q[r * COLS + c]),
        .next_state_o (next_board_s[r * COLS + c])
      );
    end
  end

  // Control FSM: mode transitions, row pointer and tick prescaler
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pre_d       = pre_q;
    update_s    = 1'b0;
    load_wr_s   = 1'b0;
    load_last_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (run_en) begin
          state_d = RUN;
          pre_d   = '0;
        end else if (single_step) begin
          state_d = STEP;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (load_valid) begin
          load_wr_s = 1'b1;
          if (ptr_q == PTR_W'(ROWS - 1)) begin
            load_last_s = 1'b1;
            state_d     = IDLE;
            ptr_d       = '0;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      RUN: begin
        // Leaving RUN drops any partial period
        if (!run_en) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (pre_q == PRE_W'(PERIOD - 1)) begin
          update_s = 1'b1;
          pre_d    = '0;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      STEP: begin
        update_s = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Board, generation and still-life datapath
  always_comb begin
    board_d  = board_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    if (update_s) begin
      board_d  = next_board_s;
      gen_d    = gen_q + GEN_W'(1);
      stable_d = (next_board_s == board_q);
    end else if (load_wr_s) begin
      board_d[int'(ptr_q) * COLS +: COLS] = load_row;
      if (load_last_s) begin
        gen_d    = '0;
        stable_d = 1'b0;
      end else begin
        gen_d = gen_q;
      end
    end else begin
      board_d = board_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      board_q  <= '0;
      ptr_q    <= '0;
      pre_q    <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      ptr_q    <= ptr_d;
      pre_q    <= pre_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
      done_q   <= load_last_s;
      busy_q   <= (state_d != IDLE);
      ready_q  <= (state_d == LOAD);
    end
  end

  assign cells      = board_q;
  assign generation = gen_q;
  assign stable     = stable_q;
  assign load_done  = done_q;
  assign load_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_conway_board.sv
// Directed bench for conway_board: two instances (8x8 toroidal PERIOD=1, 5x5 bounded PERIOD=3)
// checked every cycle against a neighbour-counting Life model plus hand-computed boards.

module tb_conway_board;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        ld_start[2];
  logic        ld_valid[2];
  logic        run[2];
  logic        step[2];
  logic [7:0]  ld_row[2];
  logic        lr[2];
  logic        ldone[2];
  logic        stab[2];
  logic        bsy[2];
  logic [15:0] gen[2];
  logic [63:0] cells_a;
  logic [24:0] cells_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [63:0] exp_cells[2];
  logic [15:0] exp_gen[2];
  logic        exp_stable[2];
  int          dim[2] = '{8, 5};
  int          per[2] = '{1, 3};
  bit          wrp[2] = '{1'b1, 1'b0};

  conway_board #(.ROWS(8), .COLS(8), .WRAP(1), .PERIOD(1), .GEN_W(16)) dut_a (
    .clk(clk), .rst(rst[0]), .load_start(ld_start[0]), .load_valid(ld_valid[0]),
    .load_row(ld_row[0]), .load_ready(lr[0]), .load_done(ldone[0]), .run_en(run[0]),
    .single_step(step[0]), .cells(cells_a), .generation(gen[0]), .stable(stab[0]),
    .busy(bsy[0])
  );

  conway_board #(.ROWS(5), .COLS(5), .WRAP(0), .PERIOD(3), .GEN_W(16)) dut_b (
    .clk(clk), .rst(rst[1]), .load_start(ld_start[1]), .load_valid(ld_valid[1]),
    .load_row(ld_row[1][4:0]), .load_ready(lr[1]), .load_done(ldone[1]), .run_en(run[1]),
    .single_step(step[1]), .cells(cells_b), .generation(gen[1]), .stable(stab[1]),
    .busy(bsy[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference generation: count live neighbours of every cell directly
  function automatic logic [63:0] life_step(input logic [63:0] b, input int n, input bit wrap);
    logic [63:0] nb;
    int live;
    int rr;
    int cc;
    nb = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        live = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + n) % n;
              cc = (cc + n) % n;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < n && cc >= 0 && cc < n)
              live += int'(b[rr * n + cc]);
          end
        end
        nb[r * n + c] = (live == 3) || (b[r * n + c] && live == 2);
      end
    end
    return nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_update(input int d);
    logic [63:0] nb;
    nb            = life_step(exp_cells[d], dim[d], wrp[d]);
    exp_stable[d] = (nb == exp_cells[d]);
    exp_cells[d]  = nb;
    exp_gen[d]    = exp_gen[d] + 16'd1;
  endtask

  task automatic model_reset(input int d);
    exp_cells[d]  = 64'd0;
    exp_gen[d]    = 16'd0;
    exp_stable[d] = 1'b0;
  endtask

  task automatic load_board(input int d, input logic [7:0][7:0] rows, input bit gaps);
    ld_start[d] = 1'b1;
    tick();
    ld_start[d] = 1'b0;
    check("load_ready_on", 64'(lr[d]), 64'd1);
    check("load_busy", 64'(bsy[d]), 64'd1);
    for (int i = 0; i < dim[d]; i++) begin
      if (gaps) begin
        ld_valid[d] = 1'b0;
        ld_row[d]   = 8'hFF;
        run[d]      = (i == 2);
        tick();
        run[d] = 1'b0;
        check("load_done_gap", 64'(ldone[d]), 64'd0);
      end
      ld_valid[d] = 1'b1;
      ld_row[d]   = rows[i];
      tick();
      ld_valid[d] = 1'b0;
      for (int c = 0; c < dim[d]; c++) exp_cells[d][i * dim[d] + c] = rows[i][c];
      if (i == dim[d] - 1) begin
        exp_gen[d]    = 16'd0;
        exp_stable[d] = 1'b0;
      end
      check("load_done_pulse", 64'(ldone[d]), 64'(i == dim[d] - 1));
    end
    check("load_ready_off", 64'(lr[d]), 64'd0);
    check("load_idle", 64'(bsy[d]), 64'd0);
    tick();
    check("load_done_end", 64'(ldone[d]), 64'd0);
  endtask

  task automatic do_step(input int d);
    step[d] = 1'b1;
    tick();
    step[d] = 1'b0;
    check("step_busy", 64'(bsy[d]), 64'd1);
    tick();
    apply_update(d);
    check("step_idle", 64'(bsy[d]), 64'd0);
  endtask

  // run_en sampled high on ns consecutive edges, then low for one exit edge
  task automatic run_for(input int d, input int ns);
    run[d] = 1'b1;
    tick();
    check("run_busy", 64'(bsy[d]), 64'd1);
    for (int j = 1; j < ns; j++) begin
      tick();
      if (j % per[d] == 0) apply_update(d);
    end
    run[d] = 1'b0;
    tick();
    check("run_idle", 64'(bsy[d]), 64'd0);
  endtask

  // Cycle-by-cycle comparison of the board outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_cells", cells_a, exp_cells[0]);
      check("b_cells", 64'(cells_b), exp_cells[1]);
      for (int d = 0; d < 2; d++) begin
        check(d == 0 ? "a_gen" : "b_gen", 64'(gen[d]), 64'(exp_gen[d]));
        check(d == 0 ? "a_stable" : "b_stable", 64'(stab[d]), 64'(exp_stable[d]));
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ld_start[d] = 1'b0; ld_valid[d] = 1'b0;
      run[d] = 1'b0; step[d] = 1'b0; ld_row[d] = 8'd0;
      model_reset(d);
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", 64'(bsy[d]), 64'd0);
      check("rst_ready", 64'(lr[d]), 64'd0);
      check("rst_done", 64'(ldone[d]), 64'd0);
    end
    check("rst_cells_a", cells_a, 64'd0);

    // Blinker on the bounded 5x5 board
    load_board(1, 64'h0000_0000_0404_0400, 1'b0);
    do_step(1);
    check("blink1_cells", 64'(cells_b), 64'h3800);
    check("blink1_gen", 64'(gen[1]), 64'd1);
    check("blink1_stable", 64'(stab[1]), 64'd0);
    do_step(1);
    check("blink2_cells", 64'(cells_b), 64'h21080);
    check("blink2_gen", 64'(gen[1]), 64'd2);

    // Top-edge line: off-board neighbours must read dead
    load_board(1, 64'h07, 1'b0);
    do_step(1);
    check("edge_cells", 64'(cells_b), 64'h42);

    // PERIOD=3 run, then a fresh run must restart the prescaler
    load_board(1, 64'h0000_0000_0404_0400, 1'b0);
    run_for(1, 8);
    check("per3_gen", 64'(gen[1]), 64'd2);
    check("per3_cells", 64'(cells_b), 64'h21080);
    run_for(1, 4);
    check("per3_restart_gen", 64'(gen[1]), 64'd3);
    check("per3_restart_cells", 64'(cells_b), 64'h3800);

    // Block still life and empty board
    load_board(0, 64'h0000_0000_0006_0600, 1'b0);
    do_step(0);
    check("block_cells", cells_a, 64'h60600);
    check("block_stable", 64'(stab[0]), 64'd1);
    check("block_gen", 64'(gen[0]), 64'd1);
    load_board(0, 64'd0, 1'b0);
    do_step(0);
    check("empty_cells", cells_a, 64'd0);
    check("empty_stable", 64'(stab[0]), 64'd1);

    // Glider loaded with gapped valids, then run around the torus
    load_board(0, 64'h0000_0000_0007_0402, 1'b1);
    check("glider_gen0", 64'(gen[0]), 64'd0);
    run_for(0, 5);
    check("glider4_cells", cells_a, 64'h0E08_0400);
    check("glider4_gen", 64'(gen[0]), 64'd4);
    run_for(0, 29);
    check("glider32_cells", cells_a, 64'h0007_0402);
    check("glider32_gen", 64'(gen[0]), 64'd32);

    // Reset part-way through LOAD
    ld_start[0] = 1'b1;
    tick();
    ld_start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid[0] = 1'b1;
      ld_row[0]   = 8'hFF;
      tick();
      for (int c = 0; c < 8; c++) exp_cells[0][i * 8 + c] = 1'b1;
    end
    ld_valid[0] = 1'b0;
    rst[0]      = 1'b1;
    tick();
    rst[0] = 1'b0;
    model_reset(0);
    check("rstload_cells", cells_a, 64'd0);
    check("rstload_busy", 64'(bsy[0]), 64'd0);
    check("rstload_ready", 64'(lr[0]), 64'd0);

    // Reset part-way through RUN
    load_board(0, 64'h0000_0000_0007_0402, 1'b0);
    run[0] = 1'b1;
    tick();
    tick();
    apply_update(0);
    tick();
    apply_update(0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    run[0] = 1'b0;
    model_reset(0);
    check("rstrun_cells", cells_a, 64'd0);
    check("rstrun_gen", 64'(gen[0]), 64'd0);
    check("rstrun_busy", 64'(bsy[0]), 64'd0);
    check("rstrun_ready", 64'(lr[0]), 64'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
